// File: rtl/parser_typedefs_pkg.sv
// Shared parser types: PHS tuple width, flow-table FSM states and small helpers.
`define PHS_WIDTH_BITS 120

package parser_typedefs_pkg;

    localparam int PHS_W      = `PHS_WIDTH_BITS;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        INSERT,
        RESP
    } FLOW_STATES;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/phs_sync_fifo.sv
// Synchronous FIFO with registered full/empty; a pop frees a slot for a same-cycle push.
// DEPTH must be a power of 2, at least 2.
module phs_sync_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage arrays are not reset; pointers and flags alone decide what is readable.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/phs_flow_table.sv
// Resolves PHS tuples to flow IDs by sequential search of a small associative table,
// learning new flows on a miss and replacing entries round-robin once the table is full.
module phs_flow_table
    import parser_typedefs_pkg::*;
#(
    parameter  int NUM_ENTRIES = 16,
    parameter  int KEY_W       = PHS_W,
    parameter  int FIFO_DEPTH  = 4,
    localparam int ID_W        = $clog2(NUM_ENTRIES)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [KEY_W-1:0]  phs_i,
    input  logic              phs_valid_i,
    input  logic              flush_i,
    output logic              flow_valid_o,
    input  logic              flow_ready_i,
    output logic [ID_W-1:0]   flow_id_o,
    output logic              flow_hit_o,
    output logic              flow_new_o,
    output logic [ID_W:0]     occupancy_o,
    output logic [15:0]       drop_cnt_o
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            hit;
        logic            is_new;
    } FlowResult;

    FLOW_STATES       state;
    FLOW_STATES       state_next;

    logic [KEY_W-1:0] table_key [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] table_valid;
    logic [KEY_W-1:0] key_q;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  free_idx;
    logic [ID_W-1:0]  victim;
    logic [ID_W-1:0]  ins_target;
    logic             free_found;
    logic             flush_pending;
    logic [ID_W:0]    occupancy;
    logic [15:0]      drop_cnt;
    FlowResult        result_q;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [KEY_W-1:0] fifo_rdata;
    logic             drop_evt;
    logic             do_flush;
    logic             entry_match;
    logic             last_idx;

    phs_sync_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (phs_valid_i),
        .pop   (fifo_pop),
        .wdata (phs_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A strobe is lost only when the FIFO is full and nothing leaves it this cycle.
    assign drop_evt    = phs_valid_i && fifo_full && !fifo_pop;
    assign entry_match = table_valid[idx] && (table_key[idx] == key_q);
    assign last_idx    = (idx == ID_W'(NUM_ENTRIES - 1));
    assign ins_target  = free_found ? free_idx : victim;

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!flush_pending && !fifo_empty) state_next = SEARCH;
            SEARCH:  if (entry_match)                   state_next = RESP;
                     else if (last_idx)                 state_next = INSERT;
            INSERT:                                     state_next = RESP;
            RESP:    if (flow_ready_i)                  state_next = IDLE;
            default:                                    state_next = IDLE;
        endcase
    end

    always_comb begin
        do_flush     = 1'b0;
        fifo_pop     = 1'b0;
        flow_valid_o = 1'b0;
        case (state)
            IDLE: begin
                do_flush = flush_pending;
                fifo_pop = !flush_pending && !fifo_empty;
            end
            RESP:    flow_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            table_valid   <= '0;
            idx           <= '0;
            free_idx      <= '0;
            free_found    <= 1'b0;
            victim        <= '0;
            occupancy     <= '0;
            flush_pending <= 1'b0;
            result_q      <= '0;
            drop_cnt      <= '0;
        end else begin
            if (drop_evt) drop_cnt <= sat_inc(drop_cnt);

            // A new flush request wins over clearing the flag, so none is ever lost.
            if (flush_i)       flush_pending <= 1'b1;
            else if (do_flush) flush_pending <= 1'b0;

            if (do_flush) begin
                table_valid <= '0;
                occupancy   <= '0;
                victim      <= '0;
            end

            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        idx        <= '0;
                        free_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (entry_match) begin
                        result_q <= '{id: idx, hit: 1'b1, is_new: 1'b0};
                    end else begin
                        if (!table_valid[idx] && !free_found) begin
                            free_idx   <= idx;
                            free_found <= 1'b1;
                        end
                        if (!last_idx) idx <= idx + ID_W'(1);
                    end
                end
                INSERT: begin
                    table_valid[ins_target] <= 1'b1;
                    result_q <= '{id: ins_target, hit: 1'b0, is_new: 1'b1};
                    if (free_found) occupancy <= occupancy + (ID_W+1)'(1);
                    else            victim    <= victim + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_pop)         key_q                 <= fifo_rdata;
        if (state == INSERT)  table_key[ins_target] <= key_q;
    end

    assign flow_id_o   = result_q.id;
    assign flow_hit_o  = result_q.hit;
    assign flow_new_o  = result_q.is_new;
    assign occupancy_o = occupancy;
    assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_phs_flow_table.sv
// Randomised scoreboard bench for phs_flow_table against a flat-array reference table.
module tb_phs_flow_table;

    localparam int NUM_ENTRIES = 16;
    localparam int KEY_W       = 120;
    localparam int FIFO_DEPTH  = 4;
    localparam int ID_W        = 4;
    localparam int POOL        = 24;

    logic              CLK = 1'b0;
    logic              reset;
    logic [KEY_W-1:0]  phs_i;
    logic              phs_valid_i;
    logic              flush_i;
    logic              flow_valid_o;
    logic              flow_ready_i;
    logic [ID_W-1:0]   flow_id_o;
    logic              flow_hit_o;
    logic              flow_new_o;
    logic [ID_W:0]     occupancy_o;
    logic [15:0]       drop_cnt_o;

    phs_flow_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_W       (KEY_W),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .phs_i        (phs_i),
        .phs_valid_i  (phs_valid_i),
        .flush_i      (flush_i),
        .flow_valid_o (flow_valid_o),
        .flow_ready_i (flow_ready_i),
        .flow_id_o    (flow_id_o),
        .flow_hit_o   (flow_hit_o),
        .flow_new_o   (flow_new_o),
        .occupancy_o  (occupancy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            hit;
        logic            is_new;
        int              occ;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference table: which keys are stored where, plus replacement bookkeeping.
    logic [KEY_W-1:0] m_key [NUM_ENTRIES];
    bit               m_valid [NUM_ENTRIES];
    int               m_victim;
    int               m_occ;
    int               m_drops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
        return r[KEY_W-1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_ENTRIES; i++) m_valid[i] = 1'b0;
        m_victim = 0;
        m_occ    = 0;
    endtask

    task automatic model_lookup(input logic [KEY_W-1:0] key);
        exp_t e;
        int   hit_at = -1;
        int   free   = -1;
        int   tgt;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (m_valid[i] && m_key[i] == key && hit_at < 0) hit_at = i;
            if (!m_valid[i] && free < 0) free = i;
        end
        if (hit_at >= 0) begin
            e.id = ID_W'(hit_at); e.hit = 1'b1; e.is_new = 1'b0;
        end else begin
            if (free >= 0) begin
                tgt = free;
                m_occ++;
            end else begin
                tgt      = m_victim;
                m_victim = (m_victim + 1) % NUM_ENTRIES;
            end
            m_key[tgt]   = key;
            m_valid[tgt] = 1'b1;
            e.id = ID_W'(tgt); e.hit = 1'b0; e.is_new = 1'b1;
        end
        e.occ = m_occ;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each accepted result and checks results stay put while stalled.
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [ID_W+1:0] prev_res   = '0;

    always @(negedge CLK) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && flow_valid_o)
                check("resp_hold", 64'({flow_id_o, flow_hit_o, flow_new_o}), 64'(prev_res));
            if (flow_valid_o && flow_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got id %0d hit %0b new %0b with nothing expected",
                             flow_id_o, flow_hit_o, flow_new_o);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id_hit_new", 64'({flow_id_o, flow_hit_o, flow_new_o}),
                          64'({e.id, e.hit, e.is_new}));
                    check("resp_occupancy", 64'(occupancy_o), 64'(e.occ));
                end
            end
            prev_valid = flow_valid_o;
            prev_ready = flow_ready_i;
            prev_res   = {flow_id_o, flow_hit_o, flow_new_o};
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        phs_valid_i = 1'b0;
        flush_i     = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        m_drops = 0;
    endtask

    task automatic strobe(input logic [KEY_W-1:0] key, input bit modelled);
        if (modelled) model_lookup(key);
        phs_i       = key;
        phs_valid_i = 1'b1;
        @(posedge CLK);
        #1;
        phs_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Cycles from the strobe cycle to the first cycle flow_valid_o is high.
    task automatic lookup_latency(input logic [KEY_W-1:0] key, input int exp_lat, input string name);
        int lat;
        strobe(key, 1'b1);
        lat = 1;
        while (!flow_valid_o && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check(name, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KEY_W-1:0] key_a;
        logic [KEY_W-1:0] key_b;
        logic [KEY_W-1:0] k;
        logic [KEY_W-1:0] fill_keys [NUM_ENTRIES+1];
        logic [KEY_W-1:0] pool [POOL];
        int               accepted;
        int               n;
        bit               saw_valid;

        phs_i        = '0;
        phs_valid_i  = 1'b0;
        flush_i      = 1'b0;
        flow_ready_i = 1'b1;
        do_reset();

        check("rst_valid",     64'(flow_valid_o), 64'(0));
        check("rst_result",    64'({flow_id_o, flow_hit_o, flow_new_o}), 64'(0));
        check("rst_occupancy", 64'(occupancy_o), 64'(0));
        check("rst_drop_cnt",  64'(drop_cnt_o), 64'(0));

        // Tuple A: first sight is a full-table miss, second is a hit at entry 0.
        key_a = {8'h06, 8'h00, 16'd1234, 16'd80, 8'd6, 32'h0A00_0001, 32'h0A00_0002};
        lookup_latency(key_a, 3 + NUM_ENTRIES, "latency_miss_a");
        drain(50);
        lookup_latency(key_a, 3, "latency_hit_a");
        drain(50);

        // Fill the table, overflow it once, then re-send the evicted key.
        do_reset();
        for (int i = 0; i <= NUM_ENTRIES; i++) begin
            fill_keys[i] = rand_key();
            strobe(fill_keys[i], 1'b1);
            drain(100);
        end
        strobe(fill_keys[0], 1'b1);
        drain(100);

        // Stalled downstream while six strobes arrive back to back.
        flow_ready_i = 1'b0;
        accepted = FIFO_DEPTH + 1;  // FSM idle, so the first strobe leaves the FIFO at once
        for (int i = 0; i < 6; i++) begin
            k = rand_key();
            if (i < accepted) model_lookup(k);
            else              m_drops++;
            phs_i       = k;
            phs_valid_i = 1'b1;
            @(posedge CLK);
            #1;
        end
        phs_valid_i = 1'b0;
        repeat (25) @(posedge CLK);
        #1;
        check("drop_cnt_overflow", 64'(drop_cnt_o), 64'(m_drops));
        check("stalled_valid", 64'(flow_valid_o), 64'(1));
        flow_ready_i = 1'b1;
        drain(400);

        // Reset while a result waits in RESP with more tuples queued behind it.
        flow_ready_i = 1'b0;
        strobe(rand_key(), 1'b1);
        n = 0;
        while (!flow_valid_o && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("resp_reached_before_reset", 64'(flow_valid_o), 64'(1));
        strobe(rand_key(), 1'b0);
        strobe(rand_key(), 1'b0);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_resp_reset_valid",     64'(flow_valid_o), 64'(0));
        check("mid_resp_reset_occupancy", 64'(occupancy_o), 64'(0));
        check("mid_resp_reset_drop_cnt",  64'(drop_cnt_o), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        m_drops      = 0;
        flow_ready_i = 1'b1;
        saw_valid    = 1'b0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (flow_valid_o) saw_valid = 1'b1;
        end
        check("post_reset_fifo_empty", 64'(saw_valid), 64'(0));

        // Flush during the search for key B at entry 3.
        do_reset();
        flow_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(rand_key(), 1'b1);
            drain(100);
        end
        key_b = rand_key();
        strobe(key_b, 1'b1);
        drain(100);
        strobe(key_b, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        flush_i = 1'b1;
        @(posedge CLK);
        #1;
        flush_i = 1'b0;
        model_clear();
        drain(100);
        strobe(key_b, 1'b1);
        drain(100);

        // Random traffic over a key pool larger than the table.
        do_reset();
        for (int i = 0; i < POOL; i++) pool[i] = rand_key();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flow_ready_i = ($urandom_range(0, 3) != 0);
            phs_valid_i  = 1'b0;
            flush_i      = 1'b0;
            if (exp_q.size() == 0 && $urandom_range(0, 39) == 0) begin
                flush_i = 1'b1;
                model_clear();
            end else if (exp_q.size() < FIFO_DEPTH && $urandom_range(0, 2) == 0) begin
                k = pool[$urandom_range(0, POOL - 1)];
                model_lookup(k);
                phs_i       = k;
                phs_valid_i = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        phs_valid_i  = 1'b0;
        flush_i      = 1'b0;
        flow_ready_i = 1'b1;
        drain(500);
        check("random_drop_cnt", 64'(drop_cnt_o), 64'(m_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phs_flow_table.md
Name: phs_flow_table

Overview:
- Sits directly downstream of the N6 packet parser.
- Consumes the 15-byte PHS tuple (tag, TOS, src/dst port, protocol, src/dst IP) on each phs_valid pulse.
- Resolves each tuple to a flow ID by sequential search of a small associative table, learning new flows on a miss.
- Returns {flow_id, hit/new} to the next stage over a valid/ready handshake.
- The parser cannot stall, so a small input FIFO absorbs bursts and counts overflow drops.

Parameters:
- NUM_ENTRIES, 16, flow table depth; must be a power of 2, at least 2.
- KEY_W, 120, PHS tuple width; matches the parser PHS output.
- FIFO_DEPTH, 4, input FIFO depth; must be a power of 2.
- ID_W, clog2(NUM_ENTRIES), derived flow-ID width; not overridable.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- phs_i  in  KEY_W  PHS tuple from the parser.
- phs_valid_i  in  1  single-cycle strobe; no backpressure possible.
- flush_i  in  1  pulse; invalidates all table entries.
- flow_valid_o  out  1  result valid.
- flow_ready_i  in  1  downstream accepts the result.
- flow_id_o  out  ID_W  table index of the matched or inserted flow.
- flow_hit_o  out  1  key was already present.
- flow_new_o  out  1  key was inserted by this lookup; it replaced a valid entry if the table was full.
- occupancy_o  out  ID_W+1  count of valid entries.
- drop_cnt_o  out  16  saturating count of tuples lost to FIFO overflow.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is CLK. Reset is honoured in any state, including mid-search or mid-response.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - FIFO empty;
  - all entry valid bits 0;
  - victim pointer 0;
  - pending-flush flag 0.
  - Key storage is not reset.
- FIFO:
  - Push on phs_valid_i if not full.
  - If full, the tuple is dropped and drop_cnt_o increments, saturating at 16'hFFFF.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot, push is accepted).
- FSM states:
  - IDLE:
    - If the pending-flush flag is set: clear all valid bits, occupancy to 0, victim pointer to 0, clear the flag. No pop this cycle; flush has priority.
    - Else if the FIFO is non-empty: pop into key_q, idx=0, free_found=0, go to SEARCH.
  - SEARCH: compares entry[idx] with key_q, one entry per cycle.
    - valid and equal: flow_id=idx, hit=1, new=0, go to RESP.
    - Entry invalid and free_found=0: record free_idx=idx, free_found=1.
    - idx==NUM_ENTRIES-1 with no match: go to INSERT. Otherwise idx+1.
  - INSERT: target is free_idx if free_found, else the victim pointer.
    - Write key_q and set valid; flow_id=target, hit=0, new=1.
    - Occupancy +1 only if a free slot was used.
    - The victim pointer advances (wrapping mod NUM_ENTRIES) only when a valid entry was replaced.
    - Go to RESP.
  - RESP:
    - flow_valid_o=1; flow_id/hit/new are held stable until flow_ready_i=1.
    - In the accepting cycle, go to IDLE; flow_valid_o deasserts the next cycle.
- Latency:
  - Strobe at cycle t into an empty FIFO with the FSM in IDLE: pop at t+1, compare of entry 0 at t+2.
  - Hit at index k: flow_valid_o first high at t+3+k.
  - Miss: flow_valid_o first high at t+3+NUM_ENTRIES.
  - Minimum 2 idle-to-idle cycles of overhead per lookup beyond the search.
- flush_i:
  - Sets the pending-flush flag in any state; the flush executes in the next IDLE cycle.
  - An in-flight lookup completes against the pre-flush table.
- Duplicate keys in the FIFO: resolved in order. The second lookup hits the entry inserted by the first.
- Invariant: equal keys never occupy two valid entries.

Decomposition:
- parser_typedefs_pkg additions:
  - FLOW_STATES enum: IDLE, SEARCH, INSERT, RESP.
  - FlowResult struct: {id, hit, new}.
  - `PHS_WIDTH_BITS = 120 constant, shared with the parser phs_o.
- One sub-module: phs_sync_fifo (parameterised width/depth; registered full/empty; drop counter kept in the parent).

Test Plan:
- Reset, then tuple A: {8'h06, TOS 0, sport 1234, dport 80, proto 6, 10.0.0.1, 10.0.0.2}, flow_ready_i=1 → flow_valid_o at t+19 (NUM_ENTRIES=16), id=0, new=1, hit=0, occupancy_o=1.
- Tuple A again → id=0, hit=1, new=0, flow_valid_o at t+3; occupancy_o stays 1.
- Insert 16 distinct keys, then a 17th → id=0, new=1, victim pointer=1, occupancy_o=16. Re-sending the key originally at entry 0 → miss, inserted at id=1.
- Hold flow_ready_i=0 while sending 6 strobes back-to-back → flow_id/hit/new stable in RESP; FIFO holds 4; drop_cnt_o increments per overflow strobe, totalling 1 or 2 depending on the pop timing of the first strobe (bench checks the exact value from the model).
- flush_i pulse during SEARCH of key B (present at idx 3) → B still returns hit, id=3; next IDLE clears the table; next lookup of B → new=1, id=0, occupancy_o=1.
- Assert reset during RESP → next cycle: flow_valid_o=0, occupancy_o=0, drop_cnt_o=0, FIFO empty.
